float_to_fixed_4: RTL and testbench

Pipelined converter from IEEE-style binary floating point to signed two's-complement fixed point in Q(INT_WID.FRA_WID) format. It is the inverse of the fixed-to-float converter, and together the two form a round-trip path on the same datapath. Fixed-format results feed downstream accumulators. The block accepts one operand per enabled cycle, has a fixed latency of 4 enabled cycles, and uses a valid-tagged pipeline that stalls under a clock enable.

---
 rtl/float_to_fixed_4.sv | 130 +++++++++++++
 tb/tb_float_to_fixed_4.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/float_to_fixed_4.sv
// float_to_fixed_4: 4-stage pipelined IEEE float to signed Q(INT_WID.FRA_WID) converter
// with round-half-away-from-zero, saturation, NaN flagging and a clock-enable stall.
module float_to_fixed_4 #(
  parameter string FLOAT_FMT = "float",
  parameter int INT_WID = 40,
  parameter int FRA_WID = 40,
  parameter int FLOAT_WID = FLOAT_FMT == "double" ? 64 : FLOAT_FMT == "byte_10" ? 80 : 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [FLOAT_WID-1:0] float_val,
  output logic                 out_valid,
  output logic [INT_WID-1:0]   fixed_integer,
  output logic [FRA_WID-1:0]   fixed_fraction,
  output logic                 overflow,
  output logic                 invalid
);
  localparam int EXP_WID = FLOAT_FMT == "double" ? 11 : FLOAT_FMT == "byte_10" ? 15 : 8;
  localparam int MANT_WID = FLOAT_WID - 1 - EXP_WID;
  localparam int BIAS = (1 << (EXP_WID - 1)) - 1;
  localparam int N = INT_WID + FRA_WID;
  localparam int K = MANT_WID + 2;
  localparam int SMAX = N + K;
  localparam int TW = $clog2(SMAX + 1);
  localparam int WID = MANT_WID + N + K + 1;
  localparam int SW = EXP_WID + 2;
  localparam int OFS = BIAS + MANT_WID - FRA_WID;
  localparam logic [1:0] CLS_ZERO = 2'd0;
  localparam logic [1:0] CLS_NORM = 2'd1;
  localparam logic [1:0] CLS_INF  = 2'd2;
  localparam logic [1:0] CLS_NAN  = 2'd3;

  logic                  sgn_in;
  logic [EXP_WID-1:0]    exp_in;
  logic [MANT_WID-1:0]   man_in;
  logic [1:0]            cls_in;
  logic signed [SW-1:0]  s;
  logic signed [31:0]    tt;
  logic [TW-1:0]         sh_in;

  logic                  v1, sg1;
  logic [1:0]            cl1;
  logic [MANT_WID:0]     m1;
  logic [TW-1:0]         sh1;
  logic                  v2, sg2, po2;
  logic [1:0]            cl2;
  logic [N+7:0]          w2;
  logic [2:0]            f2;
  logic                  v3, sg3, ov3, rb3;
  logic [1:0]            cl3;
  logic [N-1:0]          mg3;

  logic [WID-1:0]        coarse;
  logic [N+7:0]          win;
  logic [N+14:0]         fine;
  logic [N+7:0]          fine_hi;
  logic [N:0]            rmag;
  logic                  ovf_n;
  logic [N-1:0]          sat, res;

  assign sgn_in = float_val[FLOAT_WID-1];
  assign exp_in = float_val[FLOAT_WID-2:MANT_WID];
  assign man_in = float_val[MANT_WID-1:0];
  assign cls_in = exp_in == '0 ? CLS_ZERO : &exp_in ? (|man_in ? CLS_NAN : CLS_INF) : CLS_NORM;
  assign s = $signed({2'b00, exp_in}) - SW'(OFS);
  // Left-shift-only form: t = s + K places the round bit at K-1 and the integer LSB at K.
  assign tt = 32'(s) + K;
  assign sh_in = tt < 0 ? '0 : tt > SMAX ? TW'(SMAX) : tt[TW-1:0];

  assign coarse = {{(WID-MANT_WID-1){1'b0}}, m1} << {sh1[TW-1:3], 3'b000};
  assign win = (N+8)'(coarse >> (K - 8));
  assign fine = {7'b0, w2} << f2;
  assign fine_hi = (N+8)'(fine >> 7);

  assign rmag = {1'b0, mg3} + {{N{1'b0}}, rb3};
  assign ovf_n = ov3 | rmag[N] | (sg3 ? rmag[N-1] & |rmag[N-2:0] : rmag[N-1]);
  assign sat = sg3 ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  assign res = cl3 == CLS_INF ? sat : cl3 != CLS_NORM ? '0 : ovf_n ? sat :
               sg3 ? -rmag[N-1:0] : rmag[N-1:0];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v1 <= 1'b0;
      sg1 <= 1'b0;
      cl1 <= CLS_ZERO;
      m1 <= '0;
      sh1 <= '0;
      v2 <= 1'b0;
      sg2 <= 1'b0;
      cl2 <= CLS_ZERO;
      po2 <= 1'b0;
      w2 <= '0;
      f2 <= '0;
      v3 <= 1'b0;
      sg3 <= 1'b0;
      cl3 <= CLS_ZERO;
      ov3 <= 1'b0;
      mg3 <= '0;
      rb3 <= 1'b0;
      out_valid <= 1'b0;
      fixed_integer <= '0;
      fixed_fraction <= '0;
      overflow <= 1'b0;
      invalid <= 1'b0;
    end else if (ce) begin
      v1 <= in_valid;
      sg1 <= sgn_in;
      cl1 <= cls_in;
      m1 <= {1'b1, man_in};
      sh1 <= sh_in;
      v2 <= v1;
      sg2 <= sg1;
      cl2 <= cl1;
      po2 <= |coarse[WID-1:K+N];
      w2 <= win;
      f2 <= sh1[2:0];
      v3 <= v2;
      sg3 <= sg2;
      cl3 <= cl2;
      ov3 <= po2 | |fine_hi[N+7:N+1];
      mg3 <= fine_hi[N:1];
      rb3 <= fine_hi[0];
      out_valid <= v3;
      {fixed_integer, fixed_fraction} <= res;
      overflow <= cl3 == CLS_INF | (cl3 == CLS_NORM & ovf_n);
      invalid <= cl3 == CLS_NAN;
    end
endmodule

// File: tb/tb_float_to_fixed_4.sv
// tb_float_to_fixed_4: directed vector table, random stalled stream against a
// reference model, and a mid-stream reset check for float_to_fixed_4 (float, Q40.40).
module tb_float_to_fixed_4;
  logic        clk, rst, ce, in_valid;
  logic [31:0] float_val;
  logic        out_valid;
  logic [39:0] fixed_integer, fixed_fraction;
  logic        overflow, invalid;
  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] f;
    logic [39:0] i;
    logic [39:0] fr;
    logic        ovf;
    logic        inv;
  } vec_t;

  float_to_fixed_4 #(.FLOAT_FMT("float"), .INT_WID(40), .FRA_WID(40)) dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .float_val(float_val),
    .out_valid(out_valid), .fixed_integer(fixed_integer), .fixed_fraction(fixed_fraction),
    .overflow(overflow), .invalid(invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [81:0] model(input logic [31:0] f);
    logic [255:0] mm, mag;
    logic [79:0] r;
    logic neg, ov;
    int e, s;
    e = int'(f[30:23]);
    neg = f[31];
    if (e == 0) return '0;
    if (e == 255)
      return f[22:0] != 0 ? 82'b1 : {neg ? {1'b1, 79'b0} : {1'b0, {79{1'b1}}}, 2'b10};
    mm = {232'b0, 1'b1, f[22:0]};
    s = e - 110;
    if (s >= 0) mag = mm << s;
    else mag = (mm >> (-s)) + 256'(mm[-s-1]);
    ov = neg ? (mag > (256'(1) << 79)) : (mag > ((256'(1) << 79) - 256'(1)));
    r = ov ? (neg ? {1'b1, 79'b0} : {1'b0, {79{1'b1}}}) : (neg ? -mag[79:0] : mag[79:0]);
    return {r, ov, 1'b0};
  endfunction

  function automatic logic [31:0] gen();
    int kind;
    logic [7:0] e;
    kind = int'($urandom_range(0, 9));
    e = kind == 0 || kind == 1 ? 8'hFF : kind == 2 ? 8'h00 : 8'($urandom_range(80, 172));
    return {1'($urandom), e, kind == 1 ? 23'd0 : kind == 0 ? 23'($urandom) | 23'd1 : 23'($urandom)};
  endfunction

  vec_t vecs[18];
  logic [81:0] q[$];
  logic [31:0] op;
  int sent, got, stale;
  logic ce_now, iv_now;

  initial begin
    vecs[0]  = '{32'h3F800000, 40'h0000000001, 40'h0000000000, 1'b0, 1'b0};
    vecs[1]  = '{32'hC0200000, 40'hFFFFFFFFFD, 40'h8000000000, 1'b0, 1'b0};
    vecs[2]  = '{32'h2B000000, 40'h0000000000, 40'h0000000001, 1'b0, 1'b0};
    vecs[3]  = '{32'h2A800000, 40'h0000000000, 40'h0000000000, 1'b0, 1'b0};
    vecs[4]  = '{32'hAB000000, 40'hFFFFFFFFFF, 40'hFFFFFFFFFF, 1'b0, 1'b0};
    vecs[5]  = '{32'h53000000, 40'h7FFFFFFFFF, 40'hFFFFFFFFFF, 1'b1, 1'b0};
    vecs[6]  = '{32'hD3000000, 40'h8000000000, 40'h0000000000, 1'b0, 1'b0};
    vecs[7]  = '{32'h7FC00000, 40'h0000000000, 40'h0000000000, 1'b0, 1'b1};
    vecs[8]  = '{32'hFF800000, 40'h8000000000, 40'h0000000000, 1'b1, 1'b0};
    vecs[9]  = '{32'h00400000, 40'h0000000000, 40'h0000000000, 1'b0, 1'b0};
    vecs[10] = '{32'h7F800000, 40'h7FFFFFFFFF, 40'hFFFFFFFFFF, 1'b1, 1'b0};
    vecs[11] = '{32'h2BC00000, 40'h0000000000, 40'h0000000002, 1'b0, 1'b0};
    vecs[12] = '{32'hABC00000, 40'hFFFFFFFFFF, 40'hFFFFFFFFFE, 1'b0, 1'b0};
    vecs[13] = '{32'h52FFFFFF, 40'h7FFFFF8000, 40'h0000000000, 1'b0, 1'b0};
    vecs[14] = '{32'h80000000, 40'h0000000000, 40'h0000000000, 1'b0, 1'b0};
    vecs[15] = '{32'hD3000001, 40'h8000000000, 40'h0000000000, 1'b1, 1'b0};
    vecs[16] = '{32'h3FC00000, 40'h0000000001, 40'h8000000000, 1'b0, 1'b0};
    vecs[17] = '{32'hBF000000, 40'hFFFFFFFFFF, 40'h8000000000, 1'b0, 1'b0};

    rst = 1'b1;
    ce = 1'b0;
    in_valid = 1'b0;
    float_val = '0;
    repeat (2) step();
    chk("reset_state", 128'({out_valid, fixed_integer, fixed_fraction, overflow, invalid}), 128'(0));
    rst = 1'b0;
    ce = 1'b1;
    step();

    foreach (vecs[k]) begin
      float_val = vecs[k].f;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (2) step();
      chk($sformatf("vec%0d_early", k), 128'(out_valid), 128'(0));
      step();
      chk($sformatf("vec%0d", k),
          128'({out_valid, fixed_integer, fixed_fraction, overflow, invalid}),
          128'({1'b1, vecs[k].i, vecs[k].fr, vecs[k].ovf, vecs[k].inv}));
    end

    op = gen();
    sent = 0;
    got = 0;
    for (int c = 0; c < 600 && got < 20; c++) begin
      ce = $urandom_range(0, 2) != 0;
      in_valid = sent < 20 && $urandom_range(0, 3) != 0;
      float_val = op;
      ce_now = ce;
      iv_now = in_valid;
      step();
      if (ce_now && iv_now) begin
        q.push_back(model(op));
        sent++;
        op = gen();
      end
      if (ce_now && out_valid) begin
        if (q.size() == 0) chk("stream_extra", 128'(out_valid), 128'(0));
        else begin
          got++;
          chk($sformatf("stream%0d", got),
              128'({fixed_integer, fixed_fraction, overflow, invalid}), 128'(q.pop_front()));
        end
      end
    end
    in_valid = 1'b0;
    ce = 1'b1;
    chk("stream_count", 128'(got), 128'(20));
    chk("stream_sent", 128'(sent), 128'(20));

    repeat (5) step();
    float_val = 32'h3F800000;
    in_valid = 1'b1;
    repeat (4) step();
    chk("pre_rst", 128'({out_valid, fixed_integer, fixed_fraction}), 128'({1'b1, 40'h1, 40'h0}));
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_async", 128'({out_valid, fixed_integer, fixed_fraction, overflow, invalid}), 128'(0));
    step();
    rst = 1'b0;
    stale = 0;
    repeat (6) begin
      step();
      if (out_valid) stale++;
    end
    chk("rst_stale", 128'(stale), 128'(0));
    float_val = 32'hC0200000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    chk("post_rst_early", 128'(out_valid), 128'(0));
    step();
    chk("post_rst", 128'({out_valid, fixed_integer, fixed_fraction, overflow, invalid}),
        128'({1'b1, 40'hFFFFFFFFFD, 40'h8000000000, 1'b0, 1'b0}));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
